iq_sched: RTL and testbench
===========================

Name: iq_sched

Overview:
- Slot controller and select arbiter for the 4-in/1-out issue queue.
- Tracks slot occupancy and allocates up to 4 dispatched uops per cycle into free slots.
- Keeps relative age with an age matrix and grants the oldest ready slot to the single issue port each cycle.
- Applies branch-kill masks to resident and incoming uops; sits between rename/dispatch and the issue-slot array.

Parameters:
- SLOTS, 8, number of issue slots (4 to 32).
- WIDTH_IDX, 3, slot index width, equal to clog2(SLOTS).
- WIDTH_BRM, 3, branch-mask width; matches the uop BrM field.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_dis_en  in  1  dispatch group present this cycle.
- i_dis_valid  in  4  per-lane uop valid; lane 0 is oldest.
- i_dis_brm  in  4*WIDTH_BRM  per-lane branch mask; lane l occupies bits [l*WIDTH_BRM +: WIDTH_BRM].
- o_dis_ready  out  1  queue accepts a full 4-uop group this cycle.
- o_alloc_we  out  SLOTS  one-hot-per-lane slot write enables for the issue-slot array.
- o_alloc_idx  out  4*WIDTH_IDX  slot index assigned to each lane; don't-care when the lane is not allocated.
- i_slot_ready  in  SLOTS  slot operands ready (p1 and p2 set), from the issue slots.
- i_slot_brm  in  SLOTS*WIDTH_BRM  branch mask held by each slot.
- i_BrKill  in  WIDTH_BRM  branch-kill mask for this cycle.
- i_issue_stall  in  1  functional unit cannot accept an issue this cycle.
- o_issue_valid  out  1  a grant is made this cycle.
- o_issue_idx  out  WIDTH_IDX  granted slot index; 0 when o_issue_valid=0.
- o_free_cnt  out  WIDTH_IDX+1  number of free slots, from registered state.

Behaviour:
- State:
  - valid[SLOTS] register.
  - Age matrix age[i][j] (SLOTS×SLOTS), where 1 means slot i is older than slot j.
- Reset (async, i_rst_n=0):
  - valid=0, age=0.
  - o_free_cnt=SLOTS, o_dis_ready=1, o_issue_valid=0, o_issue_idx=0, o_alloc_we=0.
  - Reset asserted mid-operation drops all resident uops immediately.
- killed_i = valid[i] & |(i_slot_brm[i] & i_BrKill).
- lane_kill_l = |(i_dis_brm[l] & i_BrKill).
- Dispatch (combinational, same cycle):
  - o_dis_ready = (o_free_cnt >= 4), using only slots free at the start of the cycle.
  - Slots freed by issue or kill in this cycle are not reused until the next cycle.
  - Allocation happens only when i_dis_en & o_dis_ready.
  - Lanes with i_dis_valid=1 and lane_kill=0 receive the lowest-indexed free slots in lane order, compacted. Example: lanes 0 and 2 valid take the two lowest free slots.
  - Killed or invalid lanes get no slot, and their o_alloc_we bit stays 0.
  - If i_dis_en=1 and o_dis_ready=0: no allocation, and the group is held by the upstream stage (the controller does not buffer it).
- Select (combinational, same cycle):
  - cand_i = valid[i] & i_slot_ready[i] & ~killed_i.
  - Grant slot i if cand_i and no j with cand_j & age[j][i].
  - o_issue_valid = |cand & ~i_issue_stall.
  - Exactly one grant at most per cycle; the age matrix guarantees uniqueness.
- Update at posedge:
  - valid[i] cleared if granted or killed_i.
  - valid[k] set for each allocated slot k.
  - For a slot k allocated in lane l: age[j][k]=1 for every j with valid[j] surviving the cycle, and for slots allocated in lanes <l in the same group. age[k][*]=0.
  - Age entries of freed slots become don't-care.
  - o_free_cnt = SLOTS − popcount(valid) after the update.
- Simultaneous events: kill, issue and allocation in the same cycle are legal. A slot that is both granted and killed cannot occur, because kill masks selection.
- A granted slot's uop is read by the datapath in the grant cycle. The issue latency from ready to grant is 0 cycles.

Test Plan:
- Reset, then dispatch 4 valid lanes with brm=000 → o_alloc_idx={3,2,1,0}, o_alloc_we=0x0F; next cycle o_free_cnt=4, o_dis_ready=1.
- Second group of 4 → slots 4–7 filled, o_free_cnt=0, o_dis_ready=0; a third group with i_dis_en=1 produces o_alloc_we=0.
- Age order: slots 5 and 1 ready in the same cycle (slot 1 older) → grant idx 1, then idx 5 on the next cycle; with i_issue_stall=1, o_issue_valid=0 and both slots stay valid.
- Kill: slots 2 and 6 hold brm=010, i_BrKill=010 → both freed next cycle, o_free_cnt rises by 2; if slot 2 is ready in the kill cycle, it is not granted.
- Partial group: i_dis_valid=1010, lane 3 brm=010, i_BrKill=010, free slots {0,3,6,7} → only lane 1 is allocated, to slot 0.
- Assert reset while full with grants pending → o_free_cnt=8 and o_issue_valid=0 immediately, before the next clock.

Source files
------------

// File: rtl/iq_sched.sv
// Issue-queue slot controller: allocates dispatched uops into free slots and
// grants the oldest ready slot through an age matrix, honouring branch kills.
module iq_sched #(
  parameter int SLOTS     = 8,
  parameter int WIDTH_IDX = 3,
  parameter int WIDTH_BRM = 3
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_dis_en,
  input  logic [3:0]               i_dis_valid,
  input  logic [4*WIDTH_BRM-1:0]   i_dis_brm,
  output logic                     o_dis_ready,
  output logic [SLOTS-1:0]         o_alloc_we,
  output logic [4*WIDTH_IDX-1:0]   o_alloc_idx,
  input  logic [SLOTS-1:0]         i_slot_ready,
  input  logic [SLOTS*WIDTH_BRM-1:0] i_slot_brm,
  input  logic [WIDTH_BRM-1:0]     i_BrKill,
  input  logic                     i_issue_stall,
  output logic                     o_issue_valid,
  output logic [WIDTH_IDX-1:0]     o_issue_idx,
  output logic [WIDTH_IDX:0]       o_free_cnt
);

  logic [SLOTS-1:0]     r_valid;
  logic [SLOTS-1:0]     r_age [SLOTS];   // r_age[i][j]: slot i older than slot j

  logic [SLOTS-1:0]     w_killed;
  logic [SLOTS-1:0]     w_cand;
  logic [SLOTS-1:0]     w_grant;
  logic [SLOTS-1:0]     w_grant_vec;
  logic [SLOTS-1:0]     w_col;
  logic [SLOTS-1:0]     w_surv;
  logic [3:0]           w_lane_kill;
  logic [3:0]           w_lane_we;
  logic [WIDTH_IDX-1:0] w_lane_idx [4];
  logic [SLOTS-1:0]     w_avail;
  logic                 w_found;
  logic [WIDTH_IDX-1:0] w_pick;
  logic                 w_do_alloc;
  logic [WIDTH_IDX:0]   w_free_cnt;
  logic [SLOTS-1:0]     w_age_nxt [SLOTS];
  logic [SLOTS-1:0]     w_prior;

  always_comb begin
    for (int i = 0; i < SLOTS; i++)
      w_killed[i] = r_valid[i] & (|(i_slot_brm[i*WIDTH_BRM +: WIDTH_BRM] & i_BrKill));
    for (int l = 0; l < 4; l++)
      w_lane_kill[l] = |(i_dis_brm[l*WIDTH_BRM +: WIDTH_BRM] & i_BrKill);
  end

  assign w_cand = r_valid & i_slot_ready & ~w_killed;

  // A candidate wins only if no other candidate is older than it.
  always_comb begin
    w_grant = '0;
    w_col   = '0;
    for (int i = 0; i < SLOTS; i++) begin
      for (int j = 0; j < SLOTS; j++)
        w_col[j] = r_age[j][i];
      w_grant[i] = w_cand[i] & ~(|(w_cand & w_col));
    end
  end

  assign o_issue_valid = (|w_cand) & ~i_issue_stall;
  assign w_grant_vec   = i_issue_stall ? '0 : w_grant;

  always_comb begin
    o_issue_idx = '0;
    for (int k = 0; k < SLOTS; k++)
      if (w_grant_vec[k]) o_issue_idx = WIDTH_IDX'(k);
  end

  always_comb begin
    w_free_cnt = '0;
    for (int i = 0; i < SLOTS; i++)
      w_free_cnt = w_free_cnt + {{WIDTH_IDX{1'b0}}, ~r_valid[i]};
  end

  assign o_free_cnt  = w_free_cnt;
  assign o_dis_ready = (w_free_cnt >= (WIDTH_IDX+1)'(4));
  assign w_do_alloc  = i_dis_en & o_dis_ready;

  // Only slots free at the start of the cycle are offered; lanes take them in order.
  always_comb begin
    w_avail    = ~r_valid;
    o_alloc_we = '0;
    w_lane_we  = '0;
    w_found    = 1'b0;
    w_pick     = '0;
    for (int l = 0; l < 4; l++) w_lane_idx[l] = '0;
    for (int l = 0; l < 4; l++) begin
      if (w_do_alloc && i_dis_valid[l] && !w_lane_kill[l]) begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 0; k < SLOTS; k++) begin
          if (!w_found && w_avail[k]) begin
            w_found = 1'b1;
            w_pick  = WIDTH_IDX'(k);
          end
        end
        if (w_found) begin
          w_avail[w_pick]    = 1'b0;
          o_alloc_we[w_pick] = 1'b1;
          w_lane_we[l]       = 1'b1;
          w_lane_idx[l]      = w_pick;
        end
      end
    end
  end

  always_comb begin
    o_alloc_idx = '0;
    for (int l = 0; l < 4; l++)
      o_alloc_idx[l*WIDTH_IDX +: WIDTH_IDX] = w_lane_idx[l];
  end

  assign w_surv = r_valid & ~w_killed & ~w_grant_vec;

  // New uops are younger than every survivor and every earlier lane of the group.
  always_comb begin
    w_age_nxt = r_age;
    w_prior   = '0;
    for (int l = 0; l < 4; l++) begin
      if (w_lane_we[l]) begin
        for (int j = 0; j < SLOTS; j++)
          w_age_nxt[j][w_lane_idx[l]] = w_surv[j] | w_prior[j];
        w_age_nxt[w_lane_idx[l]] = '0;
        w_prior[w_lane_idx[l]]   = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < SLOTS; i++) r_age[i] <= '0;
    end else begin
      r_valid <= w_surv | o_alloc_we;
      r_age   <= w_age_nxt;
    end
  end

endmodule

// File: tb/tb_iq_sched.sv
// Scoreboard bench for iq_sched: expected outputs are queued per stimulus cycle
// and compared against the DUT once its combinational outputs have settled.
module tb_iq_sched;

  logic        clk;
  logic        rst_n;
  logic        dis_en;
  logic [3:0]  dis_valid;
  logic [11:0] dis_brm;
  logic        dis_ready;
  logic [7:0]  alloc_we;
  logic [11:0] alloc_idx;
  logic [7:0]  slot_ready;
  logic [23:0] slot_brm;
  logic [2:0]  brkill;
  logic        stall;
  logic        issue_valid;
  logic [2:0]  issue_idx;
  logic [3:0]  free_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [7:0]  we;
    logic [11:0] aidx;
    logic [11:0] amsk;
    logic        iv;
    logic [2:0]  ii;
    logic [3:0]  fc;
    logic        dr;
  } exp_t;

  exp_t sb[$];

  iq_sched #(.SLOTS(8), .WIDTH_IDX(3), .WIDTH_BRM(3)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_dis_en(dis_en), .i_dis_valid(dis_valid),
    .i_dis_brm(dis_brm), .o_dis_ready(dis_ready), .o_alloc_we(alloc_we),
    .o_alloc_idx(alloc_idx), .i_slot_ready(slot_ready), .i_slot_brm(slot_brm),
    .i_BrKill(brkill), .i_issue_stall(stall), .o_issue_valid(issue_valid),
    .o_issue_idx(issue_idx), .o_free_cnt(free_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [7:0] we, input logic [11:0] aidx,
                      input logic [11:0] amsk, input logic iv, input logic [2:0] ii,
                      input logic [3:0] fc, input logic dr);
    exp_t e;
    e.tag = tag; e.we = we; e.aidx = aidx; e.amsk = amsk;
    e.iv = iv; e.ii = ii; e.fc = fc; e.dr = dr;
    sb.push_back(e);
  endtask

  task automatic sb_check();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({e.tag, ".we"},   32'(alloc_we), 32'(e.we));
    chk({e.tag, ".aidx"}, 32'(alloc_idx & e.amsk), 32'(e.aidx & e.amsk));
    chk({e.tag, ".iv"},   32'(issue_valid), 32'(e.iv));
    chk({e.tag, ".ii"},   32'(issue_idx), 32'(e.ii));
    chk({e.tag, ".fc"},   32'(free_cnt), 32'(e.fc));
    chk({e.tag, ".dr"},   32'(dis_ready), 32'(e.dr));
  endtask

  task automatic drive(input logic en, input logic [3:0] v, input logic [11:0] brm,
                       input logic [7:0] rdy, input logic [2:0] kill, input logic stl);
    dis_en = en; dis_valid = v; dis_brm = brm;
    slot_ready = rdy; brkill = kill; stall = stl;
  endtask

  task automatic step();
    @(negedge clk);
    sb_check();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    slot_brm = 24'h080080;  // slots 2 and 6 carry branch mask 010
    drive(1'b0, 4'h0, 12'h000, 8'h00, 3'b000, 1'b0);
    repeat (2) @(posedge clk);
    push("reset", 8'h00, 12'h000, 12'h000, 1'b0, 3'd0, 4'd8, 1'b1);
    @(negedge clk);
    sb_check();
    @(posedge clk);
    #1 rst_n = 1'b1;

    drive(1'b1, 4'hF, 12'h000, 8'h00, 3'b000, 1'b0);
    push("grp1", 8'h0F, 12'h688, 12'hFFF, 1'b0, 3'd0, 4'd8, 1'b1);
    step();
    push("grp2", 8'hF0, 12'hFAC, 12'hFFF, 1'b0, 3'd0, 4'd4, 1'b1);
    step();
    push("grp3_full", 8'h00, 12'h000, 12'h000, 1'b0, 3'd0, 4'd0, 1'b0);
    step();

    drive(1'b0, 4'h0, 12'h000, 8'h22, 3'b000, 1'b1);
    push("stall", 8'h00, 12'h000, 12'h000, 1'b0, 3'd0, 4'd0, 1'b0);
    step();
    drive(1'b0, 4'h0, 12'h000, 8'h22, 3'b000, 1'b0);
    push("age_first", 8'h00, 12'h000, 12'h000, 1'b1, 3'd1, 4'd0, 1'b0);
    step();
    push("age_second", 8'h00, 12'h000, 12'h000, 1'b1, 3'd5, 4'd1, 1'b0);
    step();

    drive(1'b0, 4'h0, 12'h000, 8'h04, 3'b010, 1'b0);
    push("kill_mask", 8'h00, 12'h000, 12'h000, 1'b0, 3'd0, 4'd2, 1'b0);
    step();

    drive(1'b1, 4'b1010, 12'h400, 8'h00, 3'b010, 1'b0);
    push("partial", 8'h02, 12'h008, 12'h038, 1'b0, 3'd0, 4'd4, 1'b1);
    step();

    drive(1'b0, 4'h0, 12'h000, 8'h82, 3'b000, 1'b0);
    push("new_young", 8'h00, 12'h000, 12'h000, 1'b1, 3'd7, 4'd3, 1'b0);
    step();
    drive(1'b0, 4'h0, 12'h000, 8'h02, 3'b000, 1'b0);
    push("new_grant", 8'h00, 12'h000, 12'h000, 1'b1, 3'd1, 4'd4, 1'b1);
    step();

    drive(1'b1, 4'hF, 12'h000, 8'h00, 3'b000, 1'b0);
    push("refill", 8'h66, 12'hD51, 12'hFFF, 1'b0, 3'd0, 4'd5, 1'b1);
    step();

    drive(1'b0, 4'h0, 12'h000, 8'hFF, 3'b000, 1'b0);
    push("pending", 8'h00, 12'h000, 12'h000, 1'b1, 3'd0, 4'd1, 1'b0);
    @(negedge clk);
    sb_check();
    rst_n = 1'b0;
    #1;
    push("async_rst", 8'h00, 12'h000, 12'h000, 1'b0, 3'd0, 4'd8, 1'b1);
    sb_check();
    @(posedge clk);
    #1 rst_n = 1'b1;

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
